opsum_pack_fifo: RTL and testbench

Parametrised output-partial-sum FIFO for the CONV unit. It accepts one ELEM_W-bit psum per cycle from the PE side and drains either one element (zero-extended) or PACK elements packed into one OUT_W word toward the writeback/GLB path. It supersedes the fixed 4-entry, 2-element opsum buffer. The new version adds arbitrary depth, true circular packed pops, an occupancy count, a packed-ready flag and sticky overflow/underflow flags.

---
 rtl/opsum_pack_fifo_pkg.sv | 19 +
 rtl/opsum_pack_fifo_if.sv | 37 +++
 rtl/opsum_pack_fifo.sv | 118 +++++++++++
 tb/tb_opsum_pack_fifo.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opsum_pack_fifo_pkg.sv
// Shared definitions for the CONV-unit psum buffers: pop mode encoding and
// the modulo-depth pointer step.
package opsum_fifo_pkg;

    typedef enum logic {
        POP_SINGLE = 1'b0,
        POP_PACK   = 1'b1
    } pop_mode_e;

    // Valid for ptr < depth and inc <= depth, so one conditional subtract wraps.
    function automatic int unsigned ptr_add(input int unsigned ptr,
                                            input int unsigned inc,
                                            input int unsigned depth);
        int unsigned sum;
        sum = ptr + inc;
        return (sum >= depth) ? sum - depth : sum;
    endfunction

endpackage

// File: rtl/opsum_pack_fifo_if.sv
// Push/pop bundle for opsum_pack_fifo. The master is the CONV-side user and
// the slave is the FIFO itself.
interface opsum_pack_fifo_if
    import opsum_fifo_pkg::*;
#(
    parameter int ELEM_W = 16,
    parameter int DEPTH  = 8,
    parameter int PACK   = 2
);
    localparam int OUT_W = ELEM_W * PACK;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              clear_i;
    logic              push_en;
    logic [ELEM_W-1:0] push_data;
    logic              full;
    logic              pop_en;
    pop_mode_e         pop_mod;
    logic [OUT_W-1:0]  pop_data;
    logic              pop_valid;
    logic              empty;
    logic              pack_ready;
    logic [CNT_W-1:0]  count;
    logic              ovf_o;
    logic              udf_o;

    modport master (
        output clear_i, push_en, push_data, pop_en, pop_mod,
        input  full, pop_data, pop_valid, empty, pack_ready, count, ovf_o, udf_o
    );

    modport slave (
        input  clear_i, push_en, push_data, pop_en, pop_mod,
        output full, pop_data, pop_valid, empty, pack_ready, count, ovf_o, udf_o
    );

endinterface

// File: rtl/opsum_pack_fifo.sv
// Output partial-sum FIFO: one psum in per cycle, drains one zero-extended
// element or PACK elements (oldest in the LSBs) per pop, wrapping at any DEPTH.
module opsum_pack_fifo
    import opsum_fifo_pkg::*;
#(
    parameter int ELEM_W = 16,
    parameter int DEPTH  = 8,
    parameter int PACK   = 2
) (
    input  logic               clk,
    input  logic               rst,
    opsum_pack_fifo_if.slave   bus
);
    localparam int OUT_W = ELEM_W * PACK;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ELEM_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [OUT_W-1:0]  pop_data_q;
    logic              pop_valid_q;
    logic              ovf_q;
    logic              udf_q;

    logic              live;
    logic              full_w;
    logic              empty_w;
    logic              pack_ready_w;
    logic              push_acc;
    logic              pop_single_acc;
    logic              pop_pack_acc;
    logic              pop_rej;
    logic [CNT_W-1:0]  n_pop;
    logic [OUT_W-1:0]  single_word;
    logic [OUT_W-1:0]  pack_word;

    // Flags decode the pre-edge count, so a same-cycle pop never frees room for a push.
    assign full_w       = (cnt == CNT_W'(DEPTH));
    assign empty_w      = (cnt == '0);
    assign pack_ready_w = (cnt >= CNT_W'(PACK));

    // Requests presented during reset or flush are ignored and raise no flags.
    assign live           = !rst && !bus.clear_i;
    assign push_acc       = live && bus.push_en && !full_w;
    assign pop_single_acc = live && bus.pop_en && (bus.pop_mod == POP_SINGLE) && !empty_w;
    assign pop_pack_acc   = live && bus.pop_en && (bus.pop_mod == POP_PACK) && pack_ready_w;
    assign pop_rej        = live && bus.pop_en && !pop_single_acc && !pop_pack_acc;

    always_comb begin
        // NOTE: default first so every path assigns n_pop and no latch is inferred.
        n_pop = '0;
        if (pop_pack_acc)
            n_pop = CNT_W'(PACK);
        else if (pop_single_acc)
            n_pop = CNT_W'(1);
    end

    assign single_word = OUT_W'(mem[rd_ptr]);

    for (genvar k = 0; k < PACK; k++) begin : g_pack
        logic [PTR_W-1:0] idx;
        assign idx = PTR_W'(ptr_add(32'(rd_ptr), 32'(k), 32'(DEPTH)));
        assign pack_word[ELEM_W*k +: ELEM_W] = mem[idx];
    end

    // NOTE: storage has no reset; stale entries are never visible because pop_data only loads on an accepted pop.
    always_ff @(posedge clk) begin
        if (push_acc)
            mem[wr_ptr] <= push_data_w();
    end

    function automatic logic [ELEM_W-1:0] push_data_w();
        return bus.push_data;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || bus.clear_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            if (push_acc)
                wr_ptr <= PTR_W'(ptr_add(32'(wr_ptr), 32'd1, 32'(DEPTH)));

            if (pop_pack_acc) begin
                rd_ptr     <= PTR_W'(ptr_add(32'(rd_ptr), 32'(PACK), 32'(DEPTH)));
                pop_data_q <= pack_word;
            end else if (pop_single_acc) begin
                rd_ptr     <= PTR_W'(ptr_add(32'(rd_ptr), 32'd1, 32'(DEPTH)));
                pop_data_q <= single_word;
            end

            cnt         <= cnt + CNT_W'(push_acc) - n_pop;
            pop_valid_q <= pop_single_acc || pop_pack_acc;

            if (bus.push_en && full_w)
                ovf_q <= 1'b1;
            if (pop_rej)
                udf_q <= 1'b1;
        end
    end

    assign bus.full       = full_w;
    assign bus.empty      = empty_w;
    assign bus.pack_ready = pack_ready_w;
    assign bus.count      = cnt;
    assign bus.pop_data   = pop_data_q;
    assign bus.pop_valid  = pop_valid_q;
    assign bus.ovf_o      = ovf_q;
    assign bus.udf_o      = udf_q;

endmodule

// File: tb/tb_opsum_pack_fifo.sv
// Directed bench for opsum_pack_fifo: u_a is DEPTH=8/PACK=2, u_b is
// DEPTH=6/PACK=2 for the non-power-of-two wrap case.
module tb_opsum_pack_fifo;
    import opsum_fifo_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    opsum_pack_fifo_if #(.ELEM_W(16), .DEPTH(8), .PACK(2)) a_if ();
    opsum_pack_fifo_if #(.ELEM_W(16), .DEPTH(6), .PACK(2)) b_if ();

    opsum_pack_fifo #(.ELEM_W(16), .DEPTH(8), .PACK(2)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    opsum_pack_fifo #(.ELEM_W(16), .DEPTH(6), .PACK(2)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic pe, input logic [15:0] pd, input logic po,
                         input pop_mode_e pm, input logic clr);
        a_if.push_en   = pe;
        a_if.push_data = pd;
        a_if.pop_en    = po;
        a_if.pop_mod   = pm;
        a_if.clear_i   = clr;
    endtask

    task automatic drv_b(input logic pe, input logic [15:0] pd, input logic po,
                         input pop_mode_e pm, input logic clr);
        b_if.push_en   = pe;
        b_if.push_data = pd;
        b_if.pop_en    = po;
        b_if.pop_mod   = pm;
        b_if.clear_i   = clr;
    endtask

    task automatic clear_a();
        drv_a(1'b0, 16'h0, 1'b0, POP_SINGLE, 1'b1);
        cyc();
        drv_a(1'b0, 16'h0, 1'b0, POP_SINGLE, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drv_a(1'b0, 16'h0, 1'b0, POP_SINGLE, 1'b0);
        drv_b(1'b0, 16'h0, 1'b0, POP_SINGLE, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        checks++;
        if ({a_if.full, a_if.empty, a_if.pack_ready, a_if.pop_valid, a_if.ovf_o, a_if.udf_o} !== 6'b010000) begin
            errors++;
            $display("FAIL reset_flags got %b want 010000",
                     {a_if.full, a_if.empty, a_if.pack_ready, a_if.pop_valid, a_if.ovf_o, a_if.udf_o});
        end
        checks++;
        if (a_if.count !== 4'd0 || a_if.pop_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_count_data got count=%0d data=%h want 0/0", a_if.count, a_if.pop_data);
        end

        drv_a(1'b1, 16'h0011, 1'b0, POP_SINGLE, 1'b0); cyc();
        drv_a(1'b1, 16'h0022, 1'b0, POP_SINGLE, 1'b0); cyc();
        drv_a(1'b1, 16'h0033, 1'b0, POP_SINGLE, 1'b0); cyc();
        checks++;
        if (a_if.count !== 4'd3 || a_if.pack_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill3 got count=%0d pack_ready=%b want 3/1", a_if.count, a_if.pack_ready);
        end
        drv_a(1'b0, 16'h0, 1'b1, POP_SINGLE, 1'b0); cyc();
        checks++;
        if (a_if.pop_data !== 32'h0000_0011 || a_if.pop_valid !== 1'b1 || a_if.count !== 4'd2) begin
            errors++;
            $display("FAIL pre_clear_pop got data=%h valid=%b count=%0d want 00000011/1/2",
                     a_if.pop_data, a_if.pop_valid, a_if.count);
        end

        // Clear with push and pop requests present: everything ignored.
        drv_a(1'b1, 16'h0044, 1'b1, POP_SINGLE, 1'b1); cyc();
        checks++;
        if (a_if.count !== 4'd0 || a_if.empty !== 1'b1 || a_if.pop_data !== 32'h0 ||
            a_if.pop_valid !== 1'b0 || a_if.ovf_o !== 1'b0 || a_if.udf_o !== 1'b0) begin
            errors++;
            $display("FAIL clear got count=%0d empty=%b data=%h valid=%b ovf=%b udf=%b want 0/1/0/0/0/0",
                     a_if.count, a_if.empty, a_if.pop_data, a_if.pop_valid, a_if.ovf_o, a_if.udf_o);
        end

        drv_a(1'b0, 16'h0, 1'b1, POP_SINGLE, 1'b0); cyc();
        checks++;
        if (a_if.udf_o !== 1'b1 || a_if.pop_valid !== 1'b0 || a_if.count !== 4'd0) begin
            errors++;
            $display("FAIL empty_pop got udf=%b valid=%b count=%0d want 1/0/0",
                     a_if.udf_o, a_if.pop_valid, a_if.count);
        end
        clear_a();
        checks++;
        if (a_if.udf_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_udf got %b want 0", a_if.udf_o);
        end
    endtask

    task automatic test_single_order();
        for (int i = 1; i <= 8; i++) begin
            drv_a(1'b1, 16'(i), 1'b0, POP_SINGLE, 1'b0);
            cyc();
        end
        checks++;
        if (a_if.full !== 1'b1 || a_if.count !== 4'd8) begin
            errors++;
            $display("FAIL fill8 got full=%b count=%0d want 1/8", a_if.full, a_if.count);
        end
        drv_a(1'b1, 16'h0009, 1'b0, POP_SINGLE, 1'b0); cyc();
        checks++;
        if (a_if.ovf_o !== 1'b1 || a_if.count !== 4'd8) begin
            errors++;
            $display("FAIL overflow got ovf=%b count=%0d want 1/8", a_if.ovf_o, a_if.count);
        end
        for (int i = 1; i <= 8; i++) begin
            drv_a(1'b0, 16'h0, 1'b1, POP_SINGLE, 1'b0);
            cyc();
            checks++;
            if (a_if.pop_data !== 32'(i) || a_if.pop_valid !== 1'b1) begin
                errors++;
                $display("FAIL single_pop_%0d got data=%h valid=%b want %h/1",
                         i, a_if.pop_data, a_if.pop_valid, 32'(i));
            end
        end
        drv_a(1'b0, 16'h0, 1'b0, POP_SINGLE, 1'b0); cyc();
        checks++;
        if (a_if.pop_valid !== 1'b0 || a_if.pop_data !== 32'h0000_0008 || a_if.empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_idle got valid=%b data=%h empty=%b want 0/00000008/1",
                     a_if.pop_valid, a_if.pop_data, a_if.empty);
        end
        clear_a();
    endtask

    task automatic test_packed_reject();
        drv_a(1'b1, 16'h00AB, 1'b0, POP_SINGLE, 1'b0); cyc();
        drv_a(1'b1, 16'h00CD, 1'b0, POP_SINGLE, 1'b0); cyc();
        drv_a(1'b0, 16'h0, 1'b1, POP_SINGLE, 1'b0); cyc();
        drv_a(1'b0, 16'h0, 1'b1, POP_PACK, 1'b0); cyc();
        checks++;
        if (a_if.pop_valid !== 1'b0 || a_if.pop_data !== 32'h0000_00AB ||
            a_if.count !== 4'd1 || a_if.udf_o !== 1'b1) begin
            errors++;
            $display("FAIL pack_reject got valid=%b data=%h count=%0d udf=%b want 0/000000ab/1/1",
                     a_if.pop_valid, a_if.pop_data, a_if.count, a_if.udf_o);
        end
        drv_a(1'b0, 16'h0, 1'b1, POP_SINGLE, 1'b0); cyc();
        checks++;
        if (a_if.pop_data !== 32'h0000_00CD || a_if.count !== 4'd0) begin
            errors++;
            $display("FAIL after_reject got data=%h count=%0d want 000000cd/0", a_if.pop_data, a_if.count);
        end
        clear_a();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drv_a(1'b1, 16'(16'h0100 + i), 1'b0, POP_SINGLE, 1'b0);
            cyc();
        end
        for (int i = 0; i < 20; i++) begin
            drv_a(1'b1, 16'(16'h0103 + i), 1'b1, POP_SINGLE, 1'b0);
            cyc();
            checks++;
            if (a_if.pop_data !== 32'(16'h0100 + i) || a_if.pop_valid !== 1'b1 || a_if.count !== 4'd3) begin
                errors++;
                $display("FAIL b2b_%0d got data=%h valid=%b count=%0d want %h/1/3",
                         i, a_if.pop_data, a_if.pop_valid, a_if.count, 32'(16'h0100 + i));
            end
        end
        checks++;
        if (a_if.ovf_o !== 1'b0 || a_if.udf_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_flags got ovf=%b udf=%b want 0/0", a_if.ovf_o, a_if.udf_o);
        end
        clear_a();

        drv_a(1'b1, 16'h0777, 1'b1, POP_SINGLE, 1'b0); cyc();
        checks++;
        if (a_if.count !== 4'd1 || a_if.pop_valid !== 1'b0 || a_if.udf_o !== 1'b1) begin
            errors++;
            $display("FAIL empty_push_pop got count=%0d valid=%b udf=%b want 1/0/1",
                     a_if.count, a_if.pop_valid, a_if.udf_o);
        end
        drv_a(1'b0, 16'h0, 1'b1, POP_SINGLE, 1'b0); cyc();
        checks++;
        if (a_if.pop_data !== 32'h0000_0777) begin
            errors++;
            $display("FAIL empty_push_data got %h want 00000777", a_if.pop_data);
        end
        clear_a();
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 8; i++) begin
            drv_a(1'b1, 16'(16'h0200 + i), 1'b0, POP_SINGLE, 1'b0);
            cyc();
        end
        drv_a(1'b1, 16'h0F0F, 1'b1, POP_PACK, 1'b0); cyc();
        checks++;
        if (a_if.pop_data !== 32'h0201_0200 || a_if.pop_valid !== 1'b1 || a_if.count !== 4'd6 ||
            a_if.ovf_o !== 1'b1 || a_if.full !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pack got data=%h valid=%b count=%0d ovf=%b full=%b want 02010200/1/6/1/0",
                     a_if.pop_data, a_if.pop_valid, a_if.count, a_if.ovf_o, a_if.full);
        end
        for (int i = 1; i < 4; i++) begin
            drv_a(1'b0, 16'h0, 1'b1, POP_PACK, 1'b0);
            cyc();
            checks++;
            if (a_if.pop_data !== {16'(16'h0201 + 2*i), 16'(16'h0200 + 2*i)}) begin
                errors++;
                $display("FAIL full_drain_%0d got %h want %h", i, a_if.pop_data,
                         {16'(16'h0201 + 2*i), 16'(16'h0200 + 2*i)});
            end
        end
        checks++;
        if (a_if.empty !== 1'b1) begin
            errors++;
            $display("FAIL full_drain_empty got %b want 1", a_if.empty);
        end
        drv_a(1'b0, 16'h0, 1'b0, POP_SINGLE, 1'b0);
        clear_a();
    endtask

    task automatic test_packed_wrap();
        for (int i = 1; i <= 5; i++) begin
            drv_b(1'b1, 16'(16'h0B00 + i), 1'b0, POP_SINGLE, 1'b0);
            cyc();
        end
        for (int i = 1; i <= 5; i++) begin
            drv_b(1'b0, 16'h0, 1'b1, POP_SINGLE, 1'b0);
            cyc();
        end
        checks++;
        if (b_if.pop_data !== 32'h0000_0B05 || b_if.empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_prefill got data=%h empty=%b want 00000b05/1", b_if.pop_data, b_if.empty);
        end
        drv_b(1'b1, 16'hAAAA, 1'b0, POP_SINGLE, 1'b0); cyc();
        drv_b(1'b1, 16'hBBBB, 1'b0, POP_SINGLE, 1'b0); cyc();
        drv_b(1'b0, 16'h0, 1'b1, POP_PACK, 1'b0); cyc();
        checks++;
        if (b_if.pop_data !== 32'hBBBB_AAAA || b_if.pop_valid !== 1'b1 || b_if.count !== 3'd0) begin
            errors++;
            $display("FAIL wrap_pack got data=%h valid=%b count=%0d want bbbbaaaa/1/0",
                     b_if.pop_data, b_if.pop_valid, b_if.count);
        end
        drv_b(1'b1, 16'hCCCC, 1'b0, POP_SINGLE, 1'b0); cyc();
        drv_b(1'b1, 16'hDDDD, 1'b0, POP_SINGLE, 1'b0); cyc();
        drv_b(1'b0, 16'h0, 1'b1, POP_PACK, 1'b0); cyc();
        checks++;
        if (b_if.pop_data !== 32'hDDDD_CCCC || b_if.udf_o !== 1'b0 || b_if.ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_after got data=%h udf=%b ovf=%b want ddddcccc/0/0",
                     b_if.pop_data, b_if.udf_o, b_if.ovf_o);
        end
        drv_b(1'b0, 16'h0, 1'b0, POP_SINGLE, 1'b0);
        cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_order();
        test_packed_reject();
        test_back_to_back();
        test_full_pop();
        test_packed_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
